present_dec: RTL and testbench



---
 rtl/present_dec.sv | 236 +++++++++++++++++++++++
 tb/tb_present_dec.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/present_dec.sv
// present_dec: iterative PRESENT-80 decryption core, one round per clock.
//
// Operation:
//   1. KEYFWD runs the key schedule forwards for N_ROUNDS edges to reach
//      the final round key K32. The ciphertext is whitened with K32 on the
//      last of these edges.
//   2. DEC applies N_ROUNDS inverse rounds. Each round walks the key
//      schedule one step backwards, undoes the permutation layer, undoes
//      the S-box layer, and then adds the recovered round key.
//
// Ports:
//   clk         rising-edge clock
//   nrst        asynchronous active-low reset
//   start       one-cycle pulse; samples key and ciphertext when idle
//   key         80-bit cipher key, bit 79 = MSB
//   ciphertext  64-bit block to decrypt
//   plaintext   result; valid when eoc pulses, held until the next result
//   busy        high from the cycle after an accepted start until eoc
//   eoc         one-cycle end-of-computation pulse
//
// Optional build macro:
//   PRESENT_DEC_KEY_CACHE_EN - remembers the last key and its K32 value.
//   A start that repeats the cached key skips KEYFWD, so the result
//   arrives after N_ROUNDS cycles instead of 2*N_ROUNDS.

module present_dec #(
  parameter int N_ROUNDS = 31
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [79:0] key,
  input  logic [63:0] ciphertext,
  output logic [63:0] plaintext,
  output logic        busy,
  output logic        eoc
);

  typedef enum logic [1:0] {IDLE, KEYFWD, DEC} state_e;

  localparam logic [4:0] LAST_ROUND = 5'(N_ROUNDS);

  state_e      state_q, state_d;
  logic [4:0]  round_q, round_d;
  logic [79:0] keyReg_q, keyReg_d;
  logic [63:0] dataReg_q, dataReg_d;
  logic [63:0] plaintext_q, plaintext_d;
  logic        busy_q, busy_d;
  logic        eoc_q, eoc_d;

  logic [79:0] keyRot, keyNext, keyTmp, keyPrev;
  logic [63:0] dataDec;

`ifdef PRESENT_DEC_KEY_CACHE_EN
  logic [79:0] cachedKey_q, cachedKey_d;
  logic [79:0] cachedK32_q, cachedK32_d;
  logic        cacheValid_q, cacheValid_d;
  logic        cacheHit;
`endif

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    case (x)
      4'h0: sbox4 = 4'hC;  4'h1: sbox4 = 4'h5;  4'h2: sbox4 = 4'h6;  4'h3: sbox4 = 4'hB;
      4'h4: sbox4 = 4'h9;  4'h5: sbox4 = 4'h0;  4'h6: sbox4 = 4'hA;  4'h7: sbox4 = 4'hD;
      4'h8: sbox4 = 4'h3;  4'h9: sbox4 = 4'hE;  4'hA: sbox4 = 4'hF;  4'hB: sbox4 = 4'h8;
      4'hC: sbox4 = 4'h4;  4'hD: sbox4 = 4'h7;  4'hE: sbox4 = 4'h1;  default: sbox4 = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] sboxInv4(input logic [3:0] x);
    case (x)
      4'h0: sboxInv4 = 4'h5;  4'h1: sboxInv4 = 4'hE;  4'h2: sboxInv4 = 4'hF;  4'h3: sboxInv4 = 4'h8;
      4'h4: sboxInv4 = 4'hC;  4'h5: sboxInv4 = 4'h1;  4'h6: sboxInv4 = 4'h2;  4'h7: sboxInv4 = 4'hD;
      4'h8: sboxInv4 = 4'hB;  4'h9: sboxInv4 = 4'h4;  4'hA: sboxInv4 = 4'h6;  4'hB: sboxInv4 = 4'h3;
      4'hC: sboxInv4 = 4'h0;  4'hD: sboxInv4 = 4'h7;  4'hE: sboxInv4 = 4'h9;  default: sboxInv4 = 4'hA;
    endcase
  endfunction

  // Output bit j takes input bit (16*j mod 63); bit 63 maps to itself.
  function automatic logic [63:0] pLayerInv(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 63; j++) begin
      r[6'(j)] = d[6'((16 * j) % 63)];
    end
    r[63] = d[63];
    return r;
  endfunction

  function automatic logic [63:0] sLayerInv(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) begin
      r[6'(4 * n) +: 4] = sboxInv4(d[6'(4 * n) +: 4]);
    end
    return r;
  endfunction

  // Forward key-schedule step: rotate left 61, S-box on the top nibble,
  // then mix the round counter into bits 19..15.
  always_comb begin
    keyRot          = {keyReg_q[18:0], keyReg_q[79:19]};
    keyNext         = keyRot;
    keyNext[79:76]  = sbox4(keyRot[79:76]);
    keyNext[19:15]  = keyRot[19:15] ^ round_q;
  end

  // Backward key-schedule step: the forward step undone in reverse order.
  // The counter bits and the top nibble do not overlap, so both can be
  // undone from the current key directly before the right rotation.
  always_comb begin
    keyTmp         = keyReg_q;
    keyTmp[19:15]  = keyReg_q[19:15] ^ round_q;
    keyTmp[79:76]  = sboxInv4(keyReg_q[79:76]);
    keyPrev        = {keyTmp[60:0], keyTmp[79:61]};
    dataDec        = sLayerInv(pLayerInv(dataReg_q)) ^ keyPrev[79:16];
  end

`ifdef PRESENT_DEC_KEY_CACHE_EN
  assign cacheHit = cacheValid_q && (key == cachedKey_q);
`endif

  // Next-state logic for the round controller and datapath registers.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    keyReg_d    = keyReg_q;
    dataReg_d   = dataReg_q;
    plaintext_d = plaintext_q;
    busy_d      = busy_q;
    eoc_d       = 1'b0;
`ifdef PRESENT_DEC_KEY_CACHE_EN
    cachedKey_d  = cachedKey_q;
    cachedK32_d  = cachedK32_q;
    cacheValid_d = cacheValid_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
`ifdef PRESENT_DEC_KEY_CACHE_EN
          if (cacheHit) begin
            keyReg_d  = cachedK32_q;
            dataReg_d = ciphertext ^ cachedK32_q[79:16];
            round_d   = LAST_ROUND;
            state_d   = DEC;
          end else begin
            // The cache entry is rewritten now and becomes usable only
            // once this operation has produced its K32.
            cachedKey_d  = key;
            cacheValid_d = 1'b0;
            keyReg_d     = key;
            dataReg_d    = ciphertext;
            round_d      = 5'd1;
            state_d      = KEYFWD;
          end
`else
          keyReg_d  = key;
          dataReg_d = ciphertext;
          round_d   = 5'd1;
          state_d   = KEYFWD;
`endif
        end
      end

      KEYFWD: begin
        keyReg_d = keyNext;
        if (round_q == LAST_ROUND) begin
          dataReg_d = dataReg_q ^ keyNext[79:16];
          state_d   = DEC;
`ifdef PRESENT_DEC_KEY_CACHE_EN
          cachedK32_d  = keyNext;
          cacheValid_d = 1'b1;
`endif
        end else begin
          round_d = round_q + 5'd1;
        end
      end

      DEC: begin
        keyReg_d  = keyPrev;
        dataReg_d = dataDec;
        if (round_q == 5'd1) begin
          plaintext_d = dataDec;
          eoc_d       = 1'b1;
          busy_d      = 1'b0;
          round_d     = 5'd0;
          state_d     = IDLE;
        end else begin
          round_d = round_q - 5'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      round_q     <= 5'd0;
      keyReg_q    <= '0;
      dataReg_q   <= '0;
      plaintext_q <= '0;
      busy_q      <= 1'b0;
      eoc_q       <= 1'b0;
`ifdef PRESENT_DEC_KEY_CACHE_EN
      cachedKey_q  <= '0;
      cachedK32_q  <= '0;
      cacheValid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      keyReg_q    <= keyReg_d;
      dataReg_q   <= dataReg_d;
      plaintext_q <= plaintext_d;
      busy_q      <= busy_d;
      eoc_q       <= eoc_d;
`ifdef PRESENT_DEC_KEY_CACHE_EN
      cachedKey_q  <= cachedKey_d;
      cachedK32_q  <= cachedK32_d;
      cacheValid_q <= cacheValid_d;
`endif
    end
  end

  assign plaintext = plaintext_q;
  assign busy      = busy_q;
  assign eoc       = eoc_q;

endmodule

// File: tb/tb_present_dec.sv
// tb_present_dec: self-checking bench for present_dec.
//
// Expected plaintexts come from the published PRESENT-80 vectors and from a
// forward PRESENT-80 encryption model: a random plaintext is encrypted by
// the model, the ciphertext goes to the DUT, and the DUT must return the
// original plaintext. Each accepted start pushes {plaintext, eoc cycle}
// into a queue; a monitor on the falling edge pops and compares on eoc and
// also checks busy against the expected busy window every cycle.
// With PRESENT_DEC_KEY_CACHE_EN defined the expected latency follows a
// simple model of the key cache.

module tb_present_dec;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [79:0] key;
  logic [63:0] ciphertext;
  logic [63:0] plaintext;
  logic        busy;
  logic        eoc;

  present_dec dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .key        (key),
    .ciphertext (ciphertext),
    .plaintext  (plaintext),
    .busy       (busy),
    .eoc        (eoc)
  );

  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt++;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] pt;
    int          cycle;
  } exp_t;

  exp_t expQ[$];
  int   activeStart = -1;
  int   activeEnd   = -1;

`ifdef PRESENT_DEC_KEY_CACHE_EN
  bit          cacheValid = 1'b0;
  logic [79:0] cachedKey  = '0;
`endif

  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  // Textbook PRESENT-80 encryption: addRoundKey, sBoxLayer, pLayer, key
  // update, repeated 31 times, then a final key addition.
  function automatic logic [63:0] presentEnc(input logic [63:0] pt, input logic [79:0] k0);
    logic [63:0] s, t;
    logic [79:0] k;
    s = pt;
    k = k0;
    for (int i = 1; i <= 31; i++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[6'(4 * n) +: 4] = SBOX[s[6'(4 * n) +: 4]];
      t = '0;
      for (int j = 0; j < 64; j++) t[6'((j == 63) ? 63 : (16 * j) % 63)] = s[6'(j)];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = SBOX[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(i);
    end
    return s ^ k[79:16];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issues one start pulse; caller must be mid-cycle. Inputs are scrambled
  // right after the sampling edge to show they no longer matter.
  task automatic applyStimulus(input logic [79:0] k, input logic [63:0] ct, input logic [63:0] pt);
    int lat;
    key        = k;
    ciphertext = ct;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    key        = {16'($urandom), $urandom, $urandom};
    ciphertext = {$urandom, $urandom};
`ifdef PRESENT_DEC_KEY_CACHE_EN
    if (cacheValid && k == cachedKey) begin
      lat = 31;
    end else begin
      lat        = 62;
      cacheValid = 1'b1;
      cachedKey  = k;
    end
`else
    lat = 62;
`endif
    activeStart = cycleCnt;
    activeEnd   = cycleCnt + lat;
    expQ.push_back('{pt, cycleCnt + lat});
  endtask

  task automatic pulseIgnored();
    key        = {16'($urandom), $urandom, $urandom};
    ciphertext = {$urandom, $urandom};
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitEoc();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (eoc === 1'b1) return;
    end
    errors++;
    checks++;
    $display("[TB] FAIL eocTimeout: no eoc within 200 cycles, required one");
  endtask

  task automatic randomOp(input logic [79:0] k);
    logic [63:0] pt;
    pt = {$urandom, $urandom};
    applyStimulus(k, presentEnc(pt, k), pt);
    waitEoc();
  endtask

  // Monitor: busy window every cycle, result and timing on every eoc.
  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      checkOutput("busy", 64'(busy), 64'((cycleCnt >= activeStart && cycleCnt < activeEnd) ? 1 : 0));
      if (expQ.size() > 0 && cycleCnt > expQ[0].cycle) begin
        errors++;
        checks++;
        $display("[TB] FAIL missingEoc: none at cycle %0d, required one", expQ[0].cycle);
        void'(expQ.pop_front());
      end
      if (eoc === 1'b1) begin
        if (expQ.size() == 0) begin
          errors++;
          checks++;
          $display("[TB] FAIL unexpectedEoc: eoc at cycle %0d, required none", cycleCnt);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("plaintext", plaintext, e.pt);
          checkOutput("eocCycle", 64'(cycleCnt), 64'(e.cycle));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [79:0] k;
    nrst       = 1'b0;
    start      = 1'b0;
    key        = '0;
    ciphertext = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetPlaintext", plaintext, 64'h0);
    checkOutput("resetBusy", 64'(busy), 64'h0);
    checkOutput("resetEoc", 64'(eoc), 64'h0);
    #2 nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Published vectors, last two back-to-back (start during eoc).
    applyStimulus(80'h0, 64'h5579C1387B228445, 64'h0);
    waitEoc();
    repeat (2) @(negedge clk);
    applyStimulus({80{1'b1}}, 64'hE72C46C0F5945049, 64'h0);
    waitEoc();
    repeat (2) @(negedge clk);
    applyStimulus(80'h0, 64'hA112FFC72F68417B, {64{1'b1}});
    waitEoc();
    applyStimulus({80{1'b1}}, 64'h3333DCD3213210D2, {64{1'b1}});
    waitEoc();
    repeat (2) @(negedge clk);

    // Starts while busy must be ignored.
    k = {16'($urandom), $urandom, $urandom};
    applyStimulus(k, presentEnc(64'h0123456789ABCDEF, k), 64'h0123456789ABCDEF);
    repeat (4) @(negedge clk);
    pulseIgnored();
    repeat (24) @(negedge clk);
    pulseIgnored();
    waitEoc();
    repeat (2) @(negedge clk);

    // Reset in the middle of an operation.
    k = {16'($urandom), $urandom, $urandom};
    applyStimulus(k, presentEnc(64'hDEADBEEFCAFEF00D, k), 64'hDEADBEEFCAFEF00D);
    repeat (19) @(negedge clk);
    #2 nrst = 1'b0;
    expQ.delete();
    activeStart = -1;
    activeEnd   = -1;
`ifdef PRESENT_DEC_KEY_CACHE_EN
    cacheValid = 1'b0;
`endif
    @(negedge clk);
    checkOutput("midResetPlaintext", plaintext, 64'h0);
    checkOutput("midResetBusy", 64'(busy), 64'h0);
    checkOutput("midResetEoc", 64'(eoc), 64'h0);
    #2 nrst = 1'b1;
    repeat (80) @(negedge clk);
    randomOp(k);
    repeat (2) @(negedge clk);

    // Repeated key then a different key (exercises the cache when built in).
    randomOp(80'h0);
    randomOp(80'h0);
    randomOp({16'($urandom), $urandom, $urandom});

    // Random keys, sometimes repeating the previous one.
    k = {16'($urandom), $urandom, $urandom};
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 0) k = {16'($urandom), $urandom, $urandom};
      randomOp(k);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    checkOutput("queueDrained", 64'(expQ.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
